// File: rtl/demorgan_sweep_ctrl_if.sv
// Handshake/result bundle between the sweep sequencer and its board-level
// controls plus the NOR vs. inverted-AND datapath under test.
interface demorgan_sweep_ctrl_if #(
  parameter int N_IN = 3
);
  logic            start;
  logic            abort;
  logic            f1_in;
  logic            f2_in;
  logic [N_IN-1:0] vec_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_fail;
  logic            fail_valid;

  modport master (
    input  start, abort, f1_in, f2_in,
    output vec_out, busy, done, pass, err_count, first_fail, fail_valid
  );

  modport slave (
    output start, abort, f1_in, f2_in,
    input  vec_out, busy, done, pass, err_count, first_fail, fail_valid
  );
endinterface

// File: rtl/demorgan_sweep_ctrl.sv
// Self-test sequencer: walks every input vector through the gate-equivalence
// datapath, waits SETTLE cycles per vector, and tallies F1/F2 disagreements.
module demorgan_sweep_ctrl #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  demorgan_sweep_ctrl_if.master  bus
);

  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
  localparam logic [N_IN-1:0] VEC_ZERO = {N_IN{1'b0}};
  localparam logic [N_IN-1:0] VEC_ONES = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ZERO = {(N_IN+1){1'b0}};
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN+1)'(1);
  localparam logic [N_IN:0]   ERR_MAX  = {1'b1, {N_IN{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            fv_q, fv_d;
  logic            mismatch_s;

  assign mismatch_s = bus.f1_in ^ bus.f2_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;
    fv_d    = fv_q;

    case (state_q)
      S_IDLE: begin
        // abort alongside start leaves the previous results untouched
        if (bus.start && !bus.abort) begin
          vec_d   = VEC_ZERO;
          cnt_d   = CNT_LOAD;
          err_d   = ERR_ZERO;
          fv_d    = 1'b0;
          ff_d    = VEC_ZERO;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WAIT: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          vec_d   = VEC_ZERO;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_CHECK: begin
        // an aborted CHECK must not touch the partial tallies
        if (bus.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          vec_d   = VEC_ZERO;
          cnt_d   = CNT_ZERO;
        end else begin
          if (mismatch_s) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + ERR_ONE;
            end else begin
              err_d = err_q;
            end
            if (!fv_q) begin
              ff_d = vec_q;
              fv_d = 1'b1;
            end else begin
              ff_d = ff_q;
            end
          end else begin
            err_d = err_q;
          end

          if (vec_q == VEC_ONES) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == ERR_ZERO);
          end else begin
            vec_d   = vec_q + VEC_ONE;
            cnt_d   = CNT_LOAD;
            state_d = S_WAIT;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      vec_q   <= VEC_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= ERR_ZERO;
      ff_q    <= VEC_ZERO;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      fv_q    <= fv_d;
    end
  end

  assign bus.vec_out    = vec_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.first_fail = ff_q;
  assign bus.fail_valid = fv_q;

endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// Directed bench: two sequencers (SETTLE=1 and SETTLE=0) driving a behavioural
// datapath whose wiring can be deliberately broken per test.
module tb_demorgan_sweep_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   mode;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc;

  always #5 clk = ~clk;

  demorgan_sweep_ctrl_if #(.N_IN(3)) if1 ();
  demorgan_sweep_ctrl_if #(.N_IN(3)) if0 ();

  demorgan_sweep_ctrl #(.N_IN(3), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  demorgan_sweep_ctrl #(.N_IN(3), .SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

  // mode 0 correct, 1 F2 stuck 0, 2 F2 drops C, 3 F1 is OR
  function automatic logic [1:0] dp(input logic [2:0] v, input int m);
    logic a, b, c, f1, f2;
    a  = v[2]; b = v[1]; c = v[0];
    f1 = ~(a | b | c);
    f2 = ~a & ~b & ~c;
    case (m)
      1: f2 = 1'b0;
      2: f2 = ~a & ~b;
      3: f1 = a | b | c;
      default: ;
    endcase
    return {f1, f2};
  endfunction

  assign {if1.f1_in, if1.f2_in} = dp(if1.vec_out, mode);
  assign {if0.f1_in, if0.f2_in} = dp(if0.vec_out, mode);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input int sel);
    @(negedge clk);
    if (sel != 0) if1.start = 1'b1; else if0.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    if0.start = 1'b0;
  endtask

  task automatic sweep(input int sel, input int settle, input bit chk_vec, output int cycles);
    cycles = 0;
    while (((sel != 0) ? if1.busy : if0.busy) && cycles < 200) begin
      if (chk_vec)
        chk("vec_step", (sel != 0) ? if1.vec_out : if0.vec_out, cycles / (settle + 2));
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic results(input int sel, input string t, input logic d, input logic p,
                         input logic [3:0] e, input logic fv, input logic [2:0] ff);
    chk({t, "_done"},  (sel != 0) ? if1.done       : if0.done,       d);
    chk({t, "_pass"},  (sel != 0) ? if1.pass       : if0.pass,       p);
    chk({t, "_err"},   (sel != 0) ? if1.err_count  : if0.err_count,  e);
    chk({t, "_fv"},    (sel != 0) ? if1.fail_valid : if0.fail_valid, fv);
    chk({t, "_ff"},    (sel != 0) ? if1.first_fail : if0.first_fail, ff);
  endtask

  task automatic all_zero(input string t);
    chk({t, "_busy"}, if1.busy, 1'b0);
    chk({t, "_vec"},  if1.vec_out, 3'd0);
    results(1, t, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0);
  endtask

  initial begin
    rst = 1'b1;
    mode = 0;
    if1.start = 1'b0; if1.abort = 1'b0;
    if0.start = 1'b0; if0.abort = 1'b0;
    #12;
    all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // clean sweep
    mode = 0;
    go(1);
    sweep(1, 1, 1'b1, cyc);
    chk("clean_len", cyc, 24);
    chk("clean_vec_hold", if1.vec_out, 3'd7);
    results(1, "clean", 1'b1, 1'b1, 4'd0, 1'b0, 3'd0);

    // F2 stuck at 0
    mode = 1;
    go(1);
    sweep(1, 1, 1'b0, cyc);
    chk("f2zero_len", cyc, 24);
    results(1, "f2zero", 1'b1, 1'b0, 4'd1, 1'b1, 3'd0);

    // F2 without C
    mode = 2;
    go(1);
    sweep(1, 1, 1'b0, cyc);
    chk("noc_len", cyc, 24);
    results(1, "noc", 1'b1, 1'b0, 4'd1, 1'b1, 3'd1);

    // F1 inverted: every vector fails
    mode = 3;
    go(1);
    sweep(1, 1, 1'b0, cyc);
    chk("f1or_len", cyc, 24);
    results(1, "f1or", 1'b1, 1'b0, 4'd8, 1'b1, 3'd0);

    // abort mid-sweep, restart attempt while busy
    mode = 2;
    go(1);
    chk("abort_done_cleared", if1.done, 1'b0);
    repeat (5) @(negedge clk);
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    chk("restart_ignored_vec", if1.vec_out, 3'd2);
    chk("restart_ignored_busy", if1.busy, 1'b1);
    repeat (4) @(negedge clk);
    if1.abort = 1'b1;
    @(negedge clk);
    if1.abort = 1'b0;
    chk("abort_busy", if1.busy, 1'b0);
    chk("abort_vec", if1.vec_out, 3'd0);
    results(1, "abort", 1'b0, 1'b0, 4'd1, 1'b1, 3'd1);
    repeat (2) @(negedge clk);
    chk("abort_idle_hold_err", if1.err_count, 4'd1);

    // start together with abort in IDLE does nothing
    if1.start = 1'b1;
    if1.abort = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    if1.abort = 1'b0;
    chk("startabort_busy", if1.busy, 1'b0);
    chk("startabort_err", if1.err_count, 4'd1);
    chk("startabort_fv", if1.fail_valid, 1'b1);

    // fresh sweep after abort
    mode = 0;
    go(1);
    sweep(1, 1, 1'b0, cyc);
    chk("fresh_len", cyc, 24);
    results(1, "fresh", 1'b1, 1'b1, 4'd0, 1'b0, 3'd0);

    // asynchronous reset mid-WAIT, between clock edges
    go(1);
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", if1.busy, 1'b1);
    chk("pre_rst_vec", if1.vec_out, 3'd1);
    #2;
    rst = 1'b1;
    #1;
    all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // SETTLE=0 instance
    mode = 0;
    go(0);
    sweep(0, 0, 1'b1, cyc);
    chk("s0_len", cyc, 16);
    results(0, "s0", 1'b1, 1'b1, 4'd0, 1'b0, 3'd0);

    mode = 3;
    go(0);
    sweep(0, 0, 1'b0, cyc);
    chk("s0_f1or_len", cyc, 16);
    results(0, "s0_f1or", 1'b1, 1'b0, 4'd8, 1'b1, 3'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
